mem_stage_sram_ctrl: RTL and testbench
======================================

Name: mem_stage_sram_ctrl

Overview:
- MEM-stage consumer of the EXE/MEM pipeline register outputs (mem_r_en, mem_w_en, alu_result as byte address, st_val as store data).
- Performs each 32-bit load/store as two 16-bit accesses on an external asynchronous SRAM.
- Drives ready low for the whole access, so the hazard/freeze logic stalls all earlier pipeline registers until the access completes.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- WAIT_CYCLES, 2: clock cycles spent in each 16-bit half-access (legal range 1..15).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- rd_en  in  1  load request (mem_r_en from EXE/MEM register)
- wr_en  in  1  store request (mem_w_en)
- address  in  32  byte address (alu_result)
- write_data  in  32  store data (st_val)
- read_data  out  32  registered load result
- ready  out  1  high = no access pending or access completing; low = freeze pipeline
- sram_addr  out  18  SRAM half-word address
- sram_dq_out  out  16  SRAM write data
- sram_dq_oe  out  1  tri-state enable for sram_dq_out (top level builds the inout)
- sram_dq_in  in  16  SRAM read data
- sram_we_n  out  1  active-low write enable
- sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n  out  1 each  active-low chip/output/byte enables

Behaviour:
- Reset: state IDLE, wait counter 0, read_data 0, sram_we_n 1, sram_dq_oe 0, sram_addr 0, sram_dq_out 0, sram_oe_n 1. sram_ce_n, sram_ub_n and sram_lb_n are tied 0. Reset mid-access aborts immediately; there is no partial-write cleanup.
- Address mapping: off = address - BASE_ADDR, computed modulo 2^32. word = off[18:2]. Low half is at sram_addr {word,0}, high half at {word,1}. off[1:0] is ignored, so accesses are word-aligned.
- FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
  - IDLE: wr_en goes to WR_LO. Otherwise rd_en goes to RD_LO. Otherwise stay in IDLE. wr_en has priority if both are asserted.
  - Each LO/HI state lasts exactly WAIT_CYCLES cycles, timed by a 4-bit counter that clears on every state entry.
  - Sequences: RD_LO to RD_HI to DONE; WR_LO to WR_HI to DONE.
  - DONE: lasts one cycle, then returns to IDLE unconditionally. A request present in the following IDLE cycle is treated as a new access.
- Outputs are Moore, decoded from the state.
  - RD_*: sram_oe_n 0, sram_we_n 1, dq_oe 0.
  - WR_*: sram_we_n 0, dq_oe 1, sram_dq_out = write_data[15:0] in LO and write_data[31:16] in HI.
  - IDLE/DONE: we_n 1, oe_n 1, dq_oe 0.
- Read capture: on the last cycle of RD_LO, read_data[15:0] <= sram_dq_in; on the last cycle of RD_HI, read_data[31:16] <= sram_dq_in. read_data holds its value until overwritten by a later read; writes never change it.
- ready (combinational) = (state==IDLE && !rd_en && !wr_en) || state==DONE.
- Latency: with the request first seen in IDLE at cycle 0, ready is low for cycles 0..2*WAIT_CYCLES and high at cycle 2*WAIT_CYCLES+1 (DONE). The load result is valid in DONE.
- The upstream freeze holds rd_en, wr_en, address and write_data stable while ready is low. Changes to them during an access are undefined usage, but the FSM must not hang.

Decomposition:
- Shared package holds: state encoding (3-bit enum: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE), SRAM_ADDR_W=18, SRAM_DATA_W=16, and BASE_ADDR default.
- One natural sub-module: sram_wait_counter (load-clear, count up, terminal-count flag at WAIT_CYCLES-1).

Test Plan:
- Idle with rd_en=wr_en=0 -> ready=1 every cycle, sram_we_n=1, dq_oe=0.
- Store 0xDEADBEEF at address 1028, WAIT_CYCLES=2 -> sram_addr 2 driven with 0xBEEF (cycles 1-2) and sram_addr 3 with 0xDEAD (cycles 3-4), we_n low in those cycles; ready low cycles 0-4, high at cycle 5.
- Load from 1028 with an SRAM model holding the above -> read_data=0xDEADBEEF at cycle 5, ready high for exactly one cycle, then a new access starts if rd_en is still high.
- rd_en=1 and wr_en=1 together at address 1024 with write_data 0x12345678 -> write path taken: sram_addr 0/1 receive 0x5678/0x1234, read_data unchanged.
- Reset asserted during RD_HI -> outputs immediately at reset values (read_data 0, we_n 1, ready reflects IDLE); after release, a load to 1024 completes normally in 2*WAIT_CYCLES+1 cycles.
- WAIT_CYCLES=1, load at address 1024+4*0x1FFFF -> sram_addr 0x3FFFE then 0x3FFFF, ready high at cycle 3.

Source files
------------

// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM controller.
//   state_t           : controller FSM state encoding
//   SRAM_ADDR_W/DATA_W: external SRAM half-word address and data widths
//   BASE_ADDR_DEFAULT : byte address that maps to SRAM word 0
package mem_stage_sram_ctrl_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/mem_stage_sram_ctrl_sram_wait_counter.sv
// Half-access wait timer for the SRAM controller.
//   clk, rst : pipeline clock, asynchronous active-high reset
//   clr      : clears the count (asserted on every FSM state change)
//   en       : counts up while an SRAM half-access is in progress
//   tc       : high on the last cycle of a half-access (count == WAIT_CYCLES-1)
module mem_stage_sram_ctrl_sram_wait_counter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == 4'(WAIT_CYCLES - 1));

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller that performs each 32-bit load/store as two 16-bit
// accesses on an external asynchronous SRAM, holding ready low (pipeline
// freeze) until the access completes.
//   clk, rst              : pipeline clock, asynchronous active-high reset
//   rd_en, wr_en          : load / store request from the EXE/MEM register
//   address, write_data   : byte address and store data
//   read_data             : registered load result, valid in DONE
//   ready                 : low while an access is pending
//   sram_*                : SRAM address, data, tri-state enable and strobes
//
// state | meaning
// IDLE  | no access; accepts a new request (store wins over load)
// RD_LO | reading low half-word, captured on the last wait cycle
// RD_HI | reading high half-word, captured on the last wait cycle
// WR_LO | writing write_data[15:0]
// WR_HI | writing write_data[31:16]
// DONE  | access complete for one cycle, ready high
module mem_stage_sram_ctrl
    import mem_stage_sram_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_we_n,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_ub_n,
    output logic                   sram_lb_n
);

    state_t      state_q, state_d;
    logic [31:0] read_data_q, read_data_d;
    logic        tc;
    logic        cnt_clr;
    logic        cnt_en;
    logic [31:0] off;
    logic [16:0] word;
    logic        unused_off_bits;

    // Offset wraps modulo 2^32; byte-within-word bits are dropped so every
    // access is word-aligned.
    assign off             = address - BASE_ADDR;
    assign word            = off[18:2];
    assign unused_off_bits = ^{off[31:19], off[1:0]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (wr_en) begin
                    state_d = WR_LO;
                end else if (rd_en) begin
                    state_d = RD_LO;
                end
            end
            RD_LO:   if (tc) state_d = RD_HI;
            RD_HI:   if (tc) state_d = DONE;
            WR_LO:   if (tc) state_d = WR_HI;
            WR_HI:   if (tc) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counter restarts on every state entry so each half-access gets the
    // full WAIT_CYCLES regardless of what happened before.
    assign cnt_clr = (state_d != state_q);
    assign cnt_en  = (state_q == RD_LO) || (state_q == RD_HI) ||
                     (state_q == WR_LO) || (state_q == WR_HI);

    mem_stage_sram_ctrl_sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_counter (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (tc)
    );

    always_comb begin
        read_data_d = read_data_q;
        if (state_q == RD_LO && tc) begin
            read_data_d[15:0] = sram_dq_in;
        end else if (state_q == RD_HI && tc) begin
            read_data_d[31:16] = sram_dq_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            read_data_q <= read_data_d;
        end
    end

    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        sram_oe_n   = 1'b1;
        case (state_q)
            RD_LO: begin
                sram_addr = {word, 1'b0};
                sram_oe_n = 1'b0;
            end
            RD_HI: begin
                sram_addr = {word, 1'b1};
                sram_oe_n = 1'b0;
            end
            WR_LO: begin
                sram_addr   = {word, 1'b0};
                sram_dq_out = write_data[15:0];
                sram_dq_oe  = 1'b1;
                sram_we_n   = 1'b0;
            end
            WR_HI: begin
                sram_addr   = {word, 1'b1};
                sram_dq_out = write_data[31:16];
                sram_dq_oe  = 1'b1;
                sram_we_n   = 1'b0;
            end
            default: begin
            end
        endcase
    end

    assign ready     = (state_q == IDLE && !rd_en && !wr_en) || (state_q == DONE);
    assign read_data = read_data_q;
    assign sram_ce_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
module tb_mem_stage_sram_ctrl;

    localparam int W0 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- DUT 0 (WAIT_CYCLES = 2) ----------------
    logic        rd_en = 1'b0, wr_en = 1'b0;
    logic [31:0] address = '0, write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n;

    mem_stage_sram_ctrl #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(W0)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_ub_n(sram_ub_n),
        .sram_lb_n(sram_lb_n)
    );

    logic [15:0] mem [0:255];
    assign sram_dq_in = mem[sram_addr[7:0]];
    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) mem[sram_addr[7:0]] <= sram_dq_out;
    end

    // ---------------- DUT 1 (WAIT_CYCLES = 1) ----------------
    logic        rd1 = 1'b0;
    logic [31:0] addr1 = '0;
    logic [31:0] read_data1;
    logic        ready1;
    logic [17:0] sram_addr1;
    logic [15:0] unused_dq_out1, sram_dq_in1;
    logic        dq_oe1, we_n1, ce_n1, oe_n1, ub_n1, lb_n1;

    mem_stage_sram_ctrl #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(1'b0),
        .address(addr1), .write_data(32'h0), .read_data(read_data1),
        .ready(ready1), .sram_addr(sram_addr1), .sram_dq_out(unused_dq_out1),
        .sram_dq_oe(dq_oe1), .sram_dq_in(sram_dq_in1), .sram_we_n(we_n1),
        .sram_ce_n(ce_n1), .sram_oe_n(oe_n1), .sram_ub_n(ub_n1), .sram_lb_n(lb_n1)
    );

    assign sram_dq_in1 = sram_addr1[0] ? 16'hCAFE : 16'hF00D;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        is_wr;
        logic [17:0] lo_addr;
        logic [31:0] wdata;
        logic [31:0] rd;
    } txn_t;

    typedef struct packed {
        logic        wr;
        logic [17:0] addr;
        logic [15:0] data;
    } beat_t;

    txn_t  exp_q[$];
    beat_t beat_q[$];

    task automatic push_beats(input logic is_wr, input logic [17:0] a, input logic [15:0] d);
        beat_t b;
        b.wr = is_wr; b.addr = a; b.data = d;
        for (int i = 0; i < W0; i++) beat_q.push_back(b);
    endtask

    task automatic push_access(input logic is_wr, input logic [17:0] lo, input logic [31:0] wd,
                               input logic [31:0] rd);
        txn_t t;
        t.is_wr = is_wr; t.lo_addr = lo; t.wdata = wd; t.rd = rd;
        exp_q.push_back(t);
        push_beats(is_wr, lo, wd[15:0]);
        push_beats(is_wr, lo + 18'd1, wd[31:16]);
    endtask

    // Monitor: SRAM beats popped whenever a strobe is active; completions
    // popped on a rising ready edge.
    logic prev_rdy = 1'b1;
    int   low_cnt = 0, we_cnt = 0, oe_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_rdy = 1'b1;
            low_cnt = 0; we_cnt = 0; oe_cnt = 0;
        end else begin
            if (!sram_we_n || !sram_oe_n) begin
                if (beat_q.size() == 0) begin
                    chk("beat_unexpected", {14'd0, sram_addr}, 32'hFFFFFFFF);
                end else begin
                    beat_t b;
                    b = beat_q.pop_front();
                    chk("beat_addr", 32'(sram_addr), 32'(b.addr));
                    chk("beat_dir", {30'd0, sram_we_n, sram_oe_n}, b.wr ? 32'd1 : 32'd2);
                    if (b.wr) chk("beat_wdata", {15'd0, sram_dq_oe, sram_dq_out}, {15'd0, 1'b1, b.data});
                    else      chk("beat_rd_oe", 32'(sram_dq_oe), 32'd0);
                end
            end
            if (!ready) begin
                low_cnt++;
                if (!sram_we_n) we_cnt++;
                if (!sram_oe_n) oe_cnt++;
            end else if (!prev_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", 32'(low_cnt), 32'hFFFFFFFF);
                end else begin
                    txn_t t;
                    t = exp_q.pop_front();
                    chk("done_latency", 32'(low_cnt), 32'(2 * W0 + 1));
                    chk("done_read_data", read_data, t.rd);
                    chk("done_strobe_cycles", 32'((we_cnt << 8) | oe_cnt),
                        t.is_wr ? 32'(2 * W0 << 8) : 32'(2 * W0));
                    if (t.is_wr) begin
                        chk("mem_lo", 32'(mem[t.lo_addr[7:0]]), 32'(t.wdata[15:0]));
                        chk("mem_hi", 32'(mem[8'(t.lo_addr[7:0] + 8'd1)]), 32'(t.wdata[31:16]));
                    end
                end
                low_cnt = 0; we_cnt = 0; oe_cnt = 0;
            end
            prev_rdy = ready;
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        rd_en = r; wr_en = w; address = a; write_data = d;
    endtask

    task automatic drop();
        @(posedge clk);
        #1;
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic wait_level(input logic lvl, input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (ready !== lvl && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (ready !== lvl) chk(name, 32'(ready), 32'(lvl));
    endtask

    task automatic wait_done();
        wait_level(1'b0, "timeout_ready_low");
        wait_level(1'b1, "timeout_ready_high");
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_strobes", {28'd0, sram_we_n, sram_oe_n, sram_dq_oe, 1'b0}, 32'b1100);
        chk("rst_addr_dq", {sram_dq_out, 14'd0, sram_addr[1:0]}, 32'd0);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        chk("tied_enables", {29'd0, sram_ce_n, sram_ub_n, sram_lb_n}, 32'd0);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_ready", 32'(ready), 32'd1);
            chk("idle_we_oe", {30'd0, sram_we_n, sram_dq_oe}, 32'b10);
        end

        // Store 0xDEADBEEF at 1028 -> words 2/3.
        issue(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
        push_access(1'b1, 18'd2, 32'hDEADBEEF, 32'h0);
        wait_done();
        drop();

        // Two back-to-back loads with rd_en held high.
        issue(1'b1, 1'b0, 32'd1028, 32'h0);
        push_access(1'b0, 18'd2, 32'h0, 32'hDEADBEEF);
        push_access(1'b0, 18'd2, 32'h0, 32'hDEADBEEF);
        wait_done();
        wait_done();
        drop();

        // Load and store together: store wins, read_data unchanged.
        issue(1'b1, 1'b1, 32'd1024, 32'h12345678);
        push_access(1'b1, 18'd0, 32'h12345678, 32'hDEADBEEF);
        wait_done();
        drop();

        issue(1'b1, 1'b0, 32'd1024, 32'h0);
        push_access(1'b0, 18'd0, 32'h0, 32'h12345678);
        wait_done();
        drop();

        // Reset asserted in the first cycle of RD_HI.
        issue(1'b1, 1'b0, 32'd1028, 32'h0);
        push_beats(1'b0, 18'd2, 16'h0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        rd_en = 1'b0;
        #1;
        chk("abort_read_data", read_data, 32'd0);
        chk("abort_strobes", {29'd0, sram_we_n, sram_oe_n, sram_dq_oe}, 32'b110);
        chk("abort_ready", 32'(ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        issue(1'b1, 1'b0, 32'd1024, 32'h0);
        push_access(1'b0, 18'd0, 32'h0, 32'h12345678);
        wait_done();
        drop();

        // WAIT_CYCLES=1 instance at the top of the SRAM address range.
        @(posedge clk);
        #1;
        rd1 = 1'b1;
        addr1 = 32'd1024 + 32'd4 * 32'h1FFFF;
        @(negedge clk);
        chk("w1_c0_ready", 32'(ready1), 32'd0);
        @(negedge clk);
        chk("w1_c1_addr", 32'(sram_addr1), 32'h3FFFE);
        chk("w1_c1_strobes", {28'd0, ready1, oe_n1, we_n1, dq_oe1}, 32'b0010);
        @(negedge clk);
        chk("w1_c2_addr", 32'(sram_addr1), 32'h3FFFF);
        chk("w1_c2_ready", 32'(ready1), 32'd0);
        @(negedge clk);
        chk("w1_c3_ready", 32'(ready1), 32'd1);
        chk("w1_read_data", read_data1, 32'hCAFEF00D);
        chk("w1_tied", {29'd0, ce_n1, ub_n1, lb_n1}, 32'd0);
        @(posedge clk);
        #1 rd1 = 1'b0;

        repeat (4) @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("beat_q_drained", 32'(beat_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
